// File: rtl/sram_march_seq.sv
// sram_march_seq: march self-test sequencer for the async SRAM controller.
//
// Runs two passes over addresses 0..ADDR_LAST. Each pass writes every cell
// with a pattern, then reads each cell back and compares it. Pass 0 uses
// P(a) = a[7:0] ^ a[15:8] ^ a[20:16] ^ seed, and pass 1 uses ~P(a).
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : one-clock pulse; accepted in IDLE/DONE when abort is low
//   abort             : level; ends a running test and returns to IDLE
//   seed              : pattern seed, latched when start is accepted
//   busy, done        : test running / test finished
//   pass_ok           : valid while done=1; high iff no mismatches
//   phase             : 00 idle, 01 writing, 10 reading, 11 done
//   pass_idx          : current pass (0/1)
//   err_count         : saturating mismatch count
//   first_err_addr/exp/got : address, expected byte and read byte of the first mismatch
//   sram_rw/addr/wdata: request side of the controller (rw=0 means write)
//   sram_rdata        : registered read data from the controller
module sram_march_seq #(
  parameter int unsigned AW        = 21,
  parameter int unsigned DW        = 8,
  parameter int unsigned ADDR_LAST = 2**21-1,
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    seed,
  output logic          busy,
  output logic          done,
  output logic          pass_ok,
  output logic [1:0]    phase,
  output logic          pass_idx,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_exp,
  output logic [DW-1:0] first_err_got,
  output logic          sram_rw,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_SETUP, S_R_WAIT, S_R_CMP, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST   = AW'(ADDR_LAST);
  localparam logic [7:0]    WR_END = 8'(WR_CYCLES - 1);
  localparam logic [7:0]    RD_END = 8'(RD_CYCLES - 1);

  // Address bits above 20 are zero for the supported AW, so folding the
  // zero-extended address in three bytes matches the {3'b0,a[20:16]} term.
  function automatic logic [7:0] f_pattern(input logic [AW-1:0] a,
                                           input logic [7:0]    s,
                                           input logic          inv);
    logic [23:0] x;
    x = 24'(a);
    return x[7:0] ^ x[15:8] ^ x[23:16] ^ s ^ {8{inv}};
  endfunction

  state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic r_abt, w_abt_nxt;
  logic [7:0] r_seed, w_seed_nxt;

  logic          r_busy, r_done, r_pass_ok, r_pass_idx, r_sram_rw;
  logic [1:0]    r_phase;
  logic [15:0]   r_err_count;
  logic [AW-1:0] r_first_err_addr, r_sram_addr;
  logic [DW-1:0] r_first_err_exp, r_first_err_got, r_sram_wdata;

  logic          w_busy_nxt, w_done_nxt, w_pass_ok_nxt, w_pass_nxt, w_rw_nxt;
  logic [1:0]    w_phase_nxt;
  logic [15:0]   w_err_nxt;
  logic [AW-1:0] w_fa_nxt, w_addr_nxt, w_addr_step;
  logic [DW-1:0] w_fe_nxt, w_fg_nxt, w_wdata_nxt;

  logic          w_accept, w_at_last, w_mismatch;
  logic [7:0]    w_exp;

  assign w_accept    = (r_state == S_IDLE || r_state == S_DONE) && start && !abort;
  assign w_at_last   = (r_sram_addr == LAST);
  assign w_addr_step = (w_accept || w_at_last) ? '0 : r_sram_addr + AW'(1);
  assign w_exp       = f_pattern(r_sram_addr, r_seed, r_pass_idx);
  assign w_mismatch  = (sram_rdata != DW'(w_exp));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abt   <= w_abt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_state_nxt = S_W_SETUP;
      S_W_SETUP: w_state_nxt = abort ? S_IDLE : S_W_PULSE;
      // An abort during the pulse still goes through W_HOLD so rw rises
      // before the address can move.
      S_W_PULSE: if (abort || r_cnt == WR_END) w_state_nxt = S_W_HOLD;
      S_W_HOLD: begin
        if (abort || r_abt) w_state_nxt = S_IDLE;
        else                w_state_nxt = w_at_last ? S_R_SETUP : S_W_SETUP;
      end
      S_R_SETUP: w_state_nxt = abort ? S_IDLE : S_R_WAIT;
      S_R_WAIT: begin
        if (abort)                w_state_nxt = S_IDLE;
        else if (r_cnt == RD_END) w_state_nxt = S_R_CMP;
      end
      S_R_CMP: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (!w_at_last) w_state_nxt = S_R_SETUP;
        else                 w_state_nxt = r_pass_idx ? S_DONE : S_W_SETUP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_cnt_nxt = ((r_state == S_W_PULSE || r_state == S_R_WAIT) && w_state_nxt == r_state)
                ? r_cnt + 8'd1 : '0;
    w_abt_nxt = (r_state == S_W_PULSE) && abort;
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    w_seed_nxt  = r_seed;
    w_pass_nxt  = r_pass_idx;
    w_addr_nxt  = r_sram_addr;
    w_wdata_nxt = r_sram_wdata;
    w_err_nxt   = r_err_count;
    w_fa_nxt    = r_first_err_addr;
    w_fe_nxt    = r_first_err_exp;
    w_fg_nxt    = r_first_err_got;
    w_rw_nxt    = (w_state_nxt != S_W_PULSE);
    w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    unique case (w_state_nxt)
      S_IDLE:                         w_phase_nxt = 2'b00;
      S_W_SETUP, S_W_PULSE, S_W_HOLD: w_phase_nxt = 2'b01;
      S_R_SETUP, S_R_WAIT, S_R_CMP:   w_phase_nxt = 2'b10;
      default:                        w_phase_nxt = 2'b11;
    endcase

    if (w_accept) begin
      w_seed_nxt = seed;
      w_pass_nxt = 1'b0;
      w_err_nxt  = '0;
      w_fa_nxt   = '0;
      w_fe_nxt   = '0;
      w_fg_nxt   = '0;
    end else if (r_state == S_R_CMP && w_state_nxt == S_W_SETUP) begin
      w_pass_nxt = 1'b1;
    end

    if (r_state == S_R_CMP && w_mismatch) begin
      if (r_err_count != 16'hFFFF) w_err_nxt = r_err_count + 16'd1;
      if (r_err_count == '0) begin
        w_fa_nxt = r_sram_addr;
        w_fe_nxt = DW'(w_exp);
        w_fg_nxt = sram_rdata;
      end
    end

    if (w_state_nxt != r_state && (w_state_nxt == S_W_SETUP || w_state_nxt == S_R_SETUP)) begin
      w_addr_nxt  = w_addr_step;
      w_wdata_nxt = DW'(f_pattern(w_addr_step, w_seed_nxt, w_pass_nxt));
    end

    w_pass_ok_nxt = (w_state_nxt == S_DONE) && (w_err_nxt == '0);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seed           <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass_ok        <= 1'b0;
      r_phase          <= '0;
      r_pass_idx       <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_first_err_exp  <= '0;
      r_first_err_got  <= '0;
      r_sram_rw        <= 1'b1;
      r_sram_addr      <= '0;
      r_sram_wdata     <= '0;
    end else begin
      r_seed           <= w_seed_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
      r_pass_ok        <= w_pass_ok_nxt;
      r_phase          <= w_phase_nxt;
      r_pass_idx       <= w_pass_nxt;
      r_err_count      <= w_err_nxt;
      r_first_err_addr <= w_fa_nxt;
      r_first_err_exp  <= w_fe_nxt;
      r_first_err_got  <= w_fg_nxt;
      r_sram_rw        <= w_rw_nxt;
      r_sram_addr      <= w_addr_nxt;
      r_sram_wdata     <= w_wdata_nxt;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass_ok        = r_pass_ok;
  assign phase          = r_phase;
  assign pass_idx       = r_pass_idx;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign first_err_exp  = r_first_err_exp;
  assign first_err_got  = r_first_err_got;
  assign sram_rw        = r_sram_rw;
  assign sram_addr      = r_sram_addr;
  assign sram_wdata     = r_sram_wdata;

endmodule

// File: tb/tb_sram_march_seq.sv
// Testbench for sram_march_seq with a 16-cell SRAM and controller model.
// The model can inject read faults: 0 ideal, 1 bit 2 stuck-at-1 at address 7,
// 2 reads always return 00, 3 a random XOR mask per address.
module tb_sram_march_seq;
  localparam int unsigned AW = 21, DW = 8, LAST = 15, WR = 2, RD = 2;
  localparam int unsigned RUN_CYCLES = 2 * (LAST + 1) * (WR + RD + 4);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [7:0]    seed = '0;
  logic          busy, done, pass_ok, pass_idx, sram_rw;
  logic [1:0]    phase;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, sram_addr;
  logic [DW-1:0] first_err_exp, first_err_got, sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  sram_march_seq #(.AW(AW), .DW(DW), .ADDR_LAST(LAST), .WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .seed(seed),
    .busy(busy), .done(done), .pass_ok(pass_ok), .phase(phase), .pass_idx(pass_idx),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory and controller model
  logic [7:0]  mem  [0:LAST];
  logic [7:0]  flip [0:LAST];
  int unsigned fault_mode = 0;

  function automatic logic [7:0] faulty(input int unsigned a, input logic [7:0] v);
    case (fault_mode)
      1:       return (a == 7) ? (v | 8'h04) : v;
      2:       return 8'h00;
      3:       return v ^ flip[a];
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!sram_rw) mem[sram_addr[3:0]] <= sram_wdata;
    else          sram_rdata <= faulty(32'(sram_addr[3:0]), mem[sram_addr[3:0]]);
  end

  // Pattern reference from the address-fold formula
  function automatic logic [7:0] pat(input int unsigned a, input logic [7:0] s, input int unsigned p);
    int unsigned v;
    v = (a & 'hFF) ^ ((a >> 8) & 'hFF) ^ ((a >> 16) & 'h1F) ^ 32'(s);
    if (p != 0) v = ~v;
    return 8'(v);
  endfunction

  // Write-timing monitor
  int          lo_run = 0, mon_bad = 0;
  bit          mon_strict = 1'b1;
  logic [AW-1:0] lo_addr;
  logic [7:0]  lo_data;
  logic [7:0]  w3 [0:1];

  always @(negedge clk) begin
    if (!reset_n) lo_run = 0;
    else begin
      if (!sram_rw) begin
        if (lo_run == 0) begin
          lo_addr = sram_addr;
          lo_data = sram_wdata;
          if (sram_addr == 3) w3[pass_idx] = sram_wdata;
        end else if (sram_addr != lo_addr || sram_wdata != lo_data) mon_bad++;
        lo_run++;
      end else if (lo_run != 0) begin
        if (mon_strict && lo_run != WR) mon_bad++;
        if (sram_addr != lo_addr || sram_wdata != lo_data) mon_bad++;
        lo_run = 0;
      end
      if (busy && sram_addr > LAST) mon_bad++;
    end
  end

  task automatic run_test(input bit poke_start, output int unsigned cyc);
    logic [7:0] keep;
    keep = seed;
    mon_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("phase_write", phase, 2'b01);
    cyc = 0;
    while (!done && cyc < RUN_CYCLES + 50) begin
      @(negedge clk);
      cyc++;
      if (poke_start && cyc == 100) begin start = 1'b1; seed = ~keep; end
      else start = 1'b0;
    end
    seed = keep;
  endtask

  task automatic wait_write(input logic p, input logic [AW-1:0] at, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!sram_rw && sram_addr == at && pass_idx == p) ok = 1'b1;
    end
  endtask

  typedef struct {
    int unsigned mode;
    logic [7:0]  sd;
    bit          poke;
    logic [15:0] err;
    logic [20:0] fa;
    logic [7:0]  fe, fg;
    logic        ok;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int unsigned cyc;
    bit ok;
    int unsigned r_errs;
    logic [20:0] r_fa;
    logic [7:0] r_fe, r_fg, e, g;
    logic [AW-1:0] a0;
    logic [7:0] d0;

    tbl[0] = '{0, 8'h5A, 1'b0, 16'd0,  21'd0, 8'h00, 8'h00, 1'b1};
    tbl[1] = '{1, 8'h00, 1'b0, 16'd1,  21'd7, 8'hF8, 8'hFC, 1'b0};
    tbl[2] = '{2, 8'h00, 1'b0, 16'd31, 21'd1, 8'h01, 8'h00, 1'b0};
    tbl[3] = '{0, 8'hC3, 1'b1, 16'd0,  21'd0, 8'h00, 8'h00, 1'b1};

    #1 reset_n = 1'b0;
    #3;
    check("rst_rw", sram_rw, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_phase", phase, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_err", err_count, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven full runs
    for (int i = 0; i < 4; i++) begin
      fault_mode = tbl[i].mode;
      seed = tbl[i].sd;
      run_test(tbl[i].poke, cyc);
      check("run_cycles", cyc, RUN_CYCLES);
      check("tbl_err", err_count, tbl[i].err);
      check("tbl_pass_ok", pass_ok, tbl[i].ok);
      check("tbl_first_addr", first_err_addr, tbl[i].fa);
      check("tbl_first_exp", first_err_exp, tbl[i].fe);
      check("tbl_first_got", first_err_got, tbl[i].fg);
      check("done_busy", busy, 0);
      check("done_phase", phase, 2'b11);
      check("write_timing", mon_bad, 0);
      check("w3_pass0", w3[0], pat(3, tbl[i].sd, 0));
      check("w3_pass1", w3[1], pat(3, tbl[i].sd, 1));
      if (i == 0) begin
        check("w3_p0_5a", w3[0], 8'h59);
        check("w3_p1_5a", w3[1], 8'hA6);
      end
    end

    // Randomized runs against the reference model
    for (int it = 0; it < 6; it++) begin
      fault_mode = $urandom_range(0, 3);
      seed = 8'($urandom);
      for (int a = 0; a <= int'(LAST); a++)
        flip[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      r_errs = 0; r_fa = '0; r_fe = '0; r_fg = '0;
      for (int p = 0; p < 2; p++)
        for (int a = 0; a <= int'(LAST); a++) begin
          e = pat(a, seed, p);
          g = faulty(a, e);
          if (g != e) begin
            if (r_errs == 0) begin r_fa = 21'(a); r_fe = e; r_fg = g; end
            r_errs++;
          end
        end
      run_test(1'b0, cyc);
      check("rnd_cycles", cyc, RUN_CYCLES);
      check("rnd_err", err_count, r_errs);
      check("rnd_pass_ok", pass_ok, (r_errs == 0) ? 1 : 0);
      check("rnd_first_addr", first_err_addr, r_fa);
      check("rnd_first_exp", first_err_exp, r_fe);
      check("rnd_first_got", first_err_got, r_fg);
      check("rnd_timing", mon_bad, 0);
    end

    // Abort during the write pulse
    fault_mode = 0; seed = 8'h21; mon_strict = 1'b0; mon_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_write(1'b0, 5, ok);
    check("abort_wait", ok, 1);
    a0 = sram_addr; d0 = sram_wdata; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_rw_rise", sram_rw, 1);
    check("abort_addr_hold", sram_addr, a0);
    check("abort_data_hold", sram_wdata, d0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_phase", phase, 0);
    check("abort_addr_idle", sram_addr, a0);
    repeat (3) @(negedge clk);
    check("abort_rw_stays", sram_rw, 1);
    check("abort_mon", mon_bad, 0);
    mon_strict = 1'b1;

    // start together with abort is ignored
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_phase", phase, 0);

    // Clean rerun after abort
    run_test(1'b0, cyc);
    check("rerun_cycles", cyc, RUN_CYCLES);
    check("rerun_pass_ok", pass_ok, 1);
    check("rerun_err", err_count, 0);

    // Reset during a pass-1 write with errors already counted
    fault_mode = 2; seed = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_write(1'b1, 4, ok);
    check("rst_wait", ok, 1);
    check("pre_rst_err", err_count, 15);
    #2 reset_n = 1'b0;
    #1;
    check("amid_rst_rw", sram_rw, 1);
    check("amid_rst_busy", busy, 0);
    check("amid_rst_err", err_count, 0);
    check("amid_rst_addr", sram_addr, 0);
    check("amid_rst_wdata", sram_wdata, 0);
    check("amid_rst_pass", pass_idx, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_phase", phase, 0);

    // Saturation from a preloaded counter
    fault_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    force dut.r_err_count = 16'hFFFD;
    #1 release dut.r_err_count;
    cyc = 0;
    while (!done && cyc < RUN_CYCLES + 50) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_done", done, 1);
    check("sat_err", err_count, 16'hFFFF);
    check("sat_pass_ok", pass_ok, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_march_seq.md
Name: sram_march_seq

Overview:
- Self-test sequencer driving the async SRAM controller's request side: rw, addr, data_f2s out; data_s2f_r in.
- Runs two full passes over the address range, each a write sweep then a read/compare sweep.
- Pass 0 uses pattern P(a) = a[7:0] ^ a[15:8] ^ {3'b0,a[20:16]} ^ seed; pass 1 uses ~P(a), so every cell bit is exercised both ways.
- Reports error count and the first failing address and data to the board-level status logic (LEDs/UART).

Parameters:
- AW, 21, address width.
- DW, 8, data width (pattern formula fixed for 8).
- ADDR_LAST, 2**21-1, last address tested; the range is always 0..ADDR_LAST.
- WR_CYCLES, 2, clocks rw is held low per write (>=1).
- RD_CYCLES, 2, clocks between address change and the compare capture (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-clock pulse; starts a test from IDLE or DONE; ignored while busy.
- abort  in  1  level; ends the test cleanly and returns to IDLE.
- seed  in  8  pattern seed, sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE/IDLE is reached.
- done  out  1  high in DONE; cleared by the next accepted start.
- pass_ok  out  1  valid when done=1; 1 iff err_count==0.
- phase  out  2  00 idle, 01 writing, 10 reading, 11 done.
- pass_idx  out  1  current pass (0/1).
- err_count  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_addr  out  AW  address of the first mismatch.
- first_err_exp  out  DW  expected byte at the first mismatch.
- first_err_got  out  DW  read byte at the first mismatch.
- sram_rw  out  1  to controller rw; 0 = write.
- sram_addr  out  AW  to controller addr.
- sram_wdata  out  DW  to controller data_f2s.
- sram_rdata  in  DW  from controller data_s2f_r, registered there and sampled every clk while rw=1.

Behaviour:
- All outputs are registered.
- Reset values: sram_rw=1, all other outputs 0, state IDLE. Reset mid-write forces sram_rw=1 immediately (async).
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, R_CMP, DONE.
- IDLE/DONE + start: latch seed; clear err_count, first_err_*, done; pass_idx=0; addr=0; go to W_SETUP.
- Write cycle:
  - W_SETUP (1 clk): addr and wdata=pattern driven, rw=1.
  - W_PULSE (WR_CYCLES clks): rw=0.
  - W_HOLD (1 clk): rw=1; addr and wdata unchanged.
  - addr and wdata never change while rw=0 or in the cycle rw rises. Cost: WR_CYCLES+2 clks per address.
  - After W_HOLD: if addr==ADDR_LAST, set addr=0 and go to R_SETUP; else addr+1 and go to W_SETUP.
- Read cycle:
  - R_SETUP (1 clk): new addr, rw=1.
  - R_WAIT (RD_CYCLES clks).
  - R_CMP (1 clk): compare sram_rdata with pattern(addr). Compare uses the value the controller captured at the last R_WAIT edge.
  - Cost: RD_CYCLES+2 clks per address.
  - On mismatch: err_count += 1 unless already at 16'hFFFF. If it is the first error since start, load first_err_addr/exp/got.
- Pass end:
  - After R_CMP at ADDR_LAST with pass_idx=0: pass_idx=1, addr=0, go to W_SETUP.
  - After R_CMP at ADDR_LAST with pass_idx=1: go to DONE; done=1, busy=0, pass_ok updated.
- Address counter never wraps past ADDR_LAST. ADDR_LAST=0 is legal (single cell).
- abort:
  - Seen in W_PULSE: finish via W_HOLD (rw raised first), then go to IDLE.
  - Seen in any other busy state: go to IDLE next clk.
  - Effect: busy=0, done=0, error registers retained.
- start in the same cycle as abort is ignored.
- Total test length: 2*(ADDR_LAST+1)*(WR_CYCLES+RD_CYCLES+4) clks from start to done.

Test Plan:
- ADDR_LAST=15, WR=2, RD=2, ideal SRAM model (behind the controller), seed=8'h5A -> done after 256 clks. pass_ok=1, err_count=0. Every write shows rw low for exactly 2 clks with stable addr/data; addr 3 written 8'h59 in pass 0 and 8'hA6 in pass 1.
- Model with bit 2 stuck-at-1 at addr 7, seed=0 -> err_count=1 (pass 1 only; pass 0 expected 07 already has bit 2 set). first_err_addr=7, exp=8'hF8, got=8'hFC.
- Model returning 8'h00 everywhere, ADDR_LAST=15, seed=0 -> err_count=31. first_err_addr=1, exp=01, got=00.
- abort during W_PULSE -> rw returns to 1 the next clk and stays there, addr stable through the rising edge, IDLE one clk later, busy=0, done=0. A following start reruns cleanly.
- reset_n low mid-write -> sram_rw=1 asynchronously, all outputs 0. Also check: start while busy is ignored, and err_count saturates at 16'hFFFF using a forced counter preload.
